// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the register-file write-port arbiter and its scoreboard.
package rf_arb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef enum logic {
        ARB_NORMAL = 1'b0,
        ARB_FORCE  = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_WB   = 2'd1,
        GNT_LL   = 2'd2
    } grant_src_t;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] addr);
        logic [NUM_REGS-1:0] vec;
        vec       = '0;
        vec[addr] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Bundle of WB/LL result, issue, hazard-check and register-file write signals around the arbiter.
interface rf_wb_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    import rf_arb_pkg::*;

    logic                  wb_valid;
    logic [REG_ADDR_W-1:0] wb_addr;
    logic [DATA_WIDTH-1:0] wb_data;
    logic                  ll_valid;
    logic                  ll_ready;
    logic [REG_ADDR_W-1:0] ll_addr;
    logic [DATA_WIDTH-1:0] ll_data;
    logic                  iss_valid;
    logic [REG_ADDR_W-1:0] iss_addr;
    logic [REG_ADDR_W-1:0] chk_rs1;
    logic [REG_ADDR_W-1:0] chk_rs2;
    logic [REG_ADDR_W-1:0] chk_rd;
    logic                  hazard;
    logic                  pipe_stall;
    logic                  rf_wr_en;
    logic [REG_ADDR_W-1:0] rf_wr_addr;
    logic [DATA_WIDTH-1:0] rf_wr_data;

    modport master (
        output wb_valid, wb_addr, wb_data,
        output ll_valid, ll_addr, ll_data,
        output iss_valid, iss_addr,
        output chk_rs1, chk_rs2, chk_rd,
        input  ll_ready, hazard, pipe_stall,
        input  rf_wr_en, rf_wr_addr, rf_wr_data
    );

    modport slave (
        input  wb_valid, wb_addr, wb_data,
        input  ll_valid, ll_addr, ll_data,
        input  iss_valid, iss_addr,
        input  chk_rs1, chk_rs2, chk_rd,
        output ll_ready, hazard, pipe_stall,
        output rf_wr_en, rf_wr_addr, rf_wr_data
    );

endinterface

// File: rtl/rf_scoreboard.sv
// 32-entry busy vector for registers with long-latency results outstanding; x0 is never marked.
module rf_scoreboard
    import rf_arb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  set_en_i,
    input  logic [REG_ADDR_W-1:0] set_addr_i,
    input  logic                  clr_en_i,
    input  logic [REG_ADDR_W-1:0] clr_addr_i,
    input  logic [REG_ADDR_W-1:0] rs1_addr_i,
    input  logic [REG_ADDR_W-1:0] rs2_addr_i,
    input  logic [REG_ADDR_W-1:0] rd_addr_i,
    output logic                  rs1_busy_o,
    output logic                  rs2_busy_o,
    output logic                  rd_busy_o
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [NUM_REGS-1:0] set_vec;
    logic [NUM_REGS-1:0] clr_vec;

    assign set_vec = (set_en_i && (set_addr_i != '0)) ? reg_onehot(set_addr_i) : '0;
    assign clr_vec = clr_en_i ? reg_onehot(clr_addr_i) : '0;

    // A new issue to a register overrides a completion landing on it in the same cycle.
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_busy
        assign busy_d[gi] = set_vec[gi] | (busy_q[gi] & ~clr_vec[gi]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign rs1_busy_o = busy_q[rs1_addr_i];
    assign rs2_busy_o = busy_q[rs2_addr_i];
    assign rd_busy_o  = busy_q[rd_addr_i];

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: WB has priority over LL, with optional starvation guard
// enabled by defining RF_ARB_STARVE_GUARD_EN.
module rf_wb_arbiter
    import rf_arb_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    rf_wb_arbiter_if.slave  bus
);

    if (STARVE_LIMIT < 1) begin : g_limit_check
        $error("STARVE_LIMIT must be at least 1");
    end

    arb_state_t            state_q;
    logic                  pipe_stall_q;
    grant_src_t            grant;
    logic                  ll_ready;
    logic                  ll_xfer;
    logic [REG_ADDR_W-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rs1_busy;
    logic                  rs2_busy;
    logic                  rd_busy;

    // Grant selection; everything is held quiet while reset is asserted.
    always_comb begin
        grant    = GNT_NONE;
        ll_ready = 1'b0;
        if (rst_n) begin
            if (state_q == ARB_FORCE) begin
                ll_ready = 1'b1;
                if (bus.ll_valid) grant = GNT_LL;
            end else begin
                ll_ready = !bus.wb_valid;
                if (bus.wb_valid)      grant = GNT_WB;
                else if (bus.ll_valid) grant = GNT_LL;
            end
        end
    end

    assign ll_xfer = bus.ll_valid && ll_ready;

    always_comb begin
        wr_addr = '0;
        wr_data = '0;
        case (grant)
            GNT_WB: begin
                wr_addr = bus.wb_addr;
                wr_data = bus.wb_data;
            end
            GNT_LL: begin
                wr_addr = bus.ll_addr;
                wr_data = bus.ll_data;
            end
            default: ;
        endcase
    end

`ifdef RF_ARB_STARVE_GUARD_EN
    localparam int                CNT_W    = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0]  LIMIT    = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0]  LIMIT_M1 = CNT_W'(STARVE_LIMIT - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] wait_cnt_q;

    // The forcing cycle lasts exactly one clock; pipe_stall is registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB_NORMAL;
            pipe_stall_q <= 1'b0;
            wait_cnt_q   <= '0;
        end else begin
            state_q      <= ARB_NORMAL;
            pipe_stall_q <= 1'b0;
            if (!bus.ll_valid || ll_xfer) begin
                wait_cnt_q <= '0;
            end else begin
                if (wait_cnt_q != LIMIT) wait_cnt_q <= wait_cnt_q + CNT_ONE;
                if (wait_cnt_q >= LIMIT_M1) begin
                    state_q      <= ARB_FORCE;
                    pipe_stall_q <= 1'b1;
                end
            end
        end
    end
`else
    assign state_q      = ARB_NORMAL;
    assign pipe_stall_q = 1'b0;
`endif

    rf_scoreboard u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .set_en_i   (bus.iss_valid),
        .set_addr_i (bus.iss_addr),
        .clr_en_i   (ll_xfer),
        .clr_addr_i (bus.ll_addr),
        .rs1_addr_i (bus.chk_rs1),
        .rs2_addr_i (bus.chk_rs2),
        .rd_addr_i  (bus.chk_rd),
        .rs1_busy_o (rs1_busy),
        .rs2_busy_o (rs2_busy),
        .rd_busy_o  (rd_busy)
    );

    assign bus.ll_ready   = ll_ready;
    assign bus.pipe_stall = pipe_stall_q;
    assign bus.hazard     = rst_n && (rs1_busy || rs2_busy || rd_busy);
    assign bus.rf_wr_en   = (grant != GNT_NONE) && (wr_addr != '0);
    assign bus.rf_wr_addr = wr_addr;
    assign bus.rf_wr_data = wr_data;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed plus randomized bench for rf_wb_arbiter against a cycle-level behavioural model.
module tb_rf_wb_arbiter;
    import rf_arb_pkg::*;

    localparam int DW = 32;
    localparam int SL = 4;
`ifdef RF_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rf_wb_arbiter_if #(.DATA_WIDTH(DW)) bus_if ();

    rf_wb_arbiter #(.DATA_WIDTH(DW), .STARVE_LIMIT(SL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    // Model: which registers await an LL result, how long LL has been refused, forced grant due.
    bit busy_m [NUM_REGS];
    int blocked_m;
    bit force_m;
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        foreach (busy_m[i]) busy_m[i] = 1'b0;
        blocked_m = 0;
        force_m   = 1'b0;
    endtask

    task automatic set_in(input logic wbv, input logic [4:0] wba, input logic [DW-1:0] wbd,
                          input logic llv, input logic [4:0] lla, input logic [DW-1:0] lld,
                          input logic issv, input logic [4:0] issa,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        bus_if.wb_valid  = wbv;  bus_if.wb_addr  = wba;  bus_if.wb_data = wbd;
        bus_if.ll_valid  = llv;  bus_if.ll_addr  = lla;  bus_if.ll_data = lld;
        bus_if.iss_valid = issv; bus_if.iss_addr = issa;
        bus_if.chk_rs1   = rs1;  bus_if.chk_rs2  = rs2;  bus_if.chk_rd  = rd;
    endtask

    // Called just after a rising edge with inputs applied; checks mid-cycle, advances the model.
    task automatic cycle(input string tag);
        logic            exp_ready, gnt_wb, gnt_ll, exp_en, exp_haz;
        logic [4:0]      exp_addr;
        logic [DW-1:0]   exp_data;
        exp_ready = force_m ? 1'b1 : !bus_if.wb_valid;
        gnt_wb    = !force_m && bus_if.wb_valid;
        gnt_ll    = bus_if.ll_valid && exp_ready;
        exp_addr  = gnt_wb ? bus_if.wb_addr : (gnt_ll ? bus_if.ll_addr : 5'd0);
        exp_data  = gnt_wb ? bus_if.wb_data : (gnt_ll ? bus_if.ll_data : '0);
        exp_en    = (gnt_wb || gnt_ll) && (exp_addr != 5'd0);
        exp_haz   = busy_m[bus_if.chk_rs1] | busy_m[bus_if.chk_rs2] | busy_m[bus_if.chk_rd];
        @(negedge clk);
        check({tag, ".ll_ready"},   64'(bus_if.ll_ready),   64'(exp_ready));
        check({tag, ".rf_wr_en"},   64'(bus_if.rf_wr_en),   64'(exp_en));
        check({tag, ".rf_wr_addr"}, 64'(bus_if.rf_wr_addr), 64'(exp_addr));
        check({tag, ".rf_wr_data"}, 64'(bus_if.rf_wr_data), 64'(exp_data));
        check({tag, ".hazard"},     64'(bus_if.hazard),     64'(exp_haz));
        check({tag, ".pipe_stall"}, 64'(bus_if.pipe_stall), 64'(force_m));
        $display("%s wb=%b/%0d ll=%b/%0d rdy=%b wr=%b@%0d:%h haz=%b stall=%b", tag,
                 bus_if.wb_valid, bus_if.wb_addr, bus_if.ll_valid, bus_if.ll_addr,
                 bus_if.ll_ready, bus_if.rf_wr_en, bus_if.rf_wr_addr, bus_if.rf_wr_data,
                 bus_if.hazard, bus_if.pipe_stall);
        @(posedge clk);
        if (gnt_ll) busy_m[bus_if.ll_addr] = 1'b0;
        if (bus_if.iss_valid && bus_if.iss_addr != 5'd0) busy_m[bus_if.iss_addr] = 1'b1;
        if (bus_if.ll_valid && !exp_ready) blocked_m++;
        else                               blocked_m = 0;
        force_m = GUARD && (blocked_m >= SL);
        #1;
    endtask

    task automatic reset_check(input string tag);
        set_in(1'b1, 5'd6, 32'h1111, 1'b1, 5'd6, 32'h2222, 1'b1, 5'd6, 5'd6, 5'd4, 5'd3);
        rst_n = 1'b0;
        @(negedge clk);
        check({tag, ".rf_wr_en"},   64'(bus_if.rf_wr_en),   64'd0);
        check({tag, ".ll_ready"},   64'(bus_if.ll_ready),   64'd0);
        check({tag, ".hazard"},     64'(bus_if.hazard),     64'd0);
        check({tag, ".pipe_stall"}, 64'(bus_if.pipe_stall), 64'd0);
        $display("%s rst_n=0 wr=%b rdy=%b haz=%b stall=%b", tag,
                 bus_if.rf_wr_en, bus_if.ll_ready, bus_if.hazard, bus_if.pipe_stall);
        model_reset();
        @(posedge clk);
        #1;
        set_in(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b0, 5'd0, 5'd6, 5'd4, 5'd3);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        set_in(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_check("rst");
        cycle("rst_idle");

        // WB beats LL, then LL drains once WB goes quiet
        set_in(1'b1, 5'd5, 32'hA5A5, 1'b1, 5'd9, 32'h1234, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
        cycle("prio_wb");
        set_in(1'b0, 5'd5, 32'hA5A5, 1'b1, 5'd9, 32'h1234, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
        cycle("prio_ll");

        // Issue x7 busy, RAW seen, then completion clears it
        set_in(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b1, 5'd7, 5'd0, 5'd0, 5'd0);
        cycle("iss7");
        set_in(1'b0, 5'd0, '0, 1'b1, 5'd7, 32'h7777, 1'b0, 5'd0, 5'd7, 5'd0, 5'd0);
        cycle("haz7_done");
        set_in(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b0, 5'd0, 5'd7, 5'd0, 5'd0);
        cycle("haz7_clear");

        // LL starvation under continuous WB traffic
        for (int i = 0; i < 7; i++) begin
            set_in(1'b1, 5'(10 + i), 32'(i), 1'b1, 5'd12, 32'hC0DE, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
            cycle($sformatf("starve%0d", i));
        end
        set_in(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
        cycle("starve_end");

        // x0 is never written nor tracked
        set_in(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, '0, 1'b1, 5'd0, 5'd0, 5'd0, 5'd0);
        cycle("x0_wb");
        set_in(1'b0, 5'd0, '0, 1'b1, 5'd0, 32'hBEEF, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
        cycle("x0_ll");

        // Same-cycle issue and completion of x3: stays busy
        set_in(1'b0, 5'd0, '0, 1'b1, 5'd3, 32'h3333, 1'b1, 5'd3, 5'd0, 5'd0, 5'd0);
        cycle("x3_both");
        set_in(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd3);
        cycle("x3_busy");

        // Reset with registers outstanding wipes the scoreboard
        set_in(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b1, 5'd4, 5'd0, 5'd0, 5'd0);
        cycle("iss4");
        reset_check("rst_mid");
        cycle("after_rst");

        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), $urandom,
                   $urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom,
                   $urandom_range(0, 9) < 3, 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            cycle($sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
